// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder and its lane aligner.
package dmem_responder_pkg;

    localparam int unsigned BE_W     = 4;
    localparam int unsigned F3_WIDTH = 3;

    localparam logic [F3_WIDTH-1:0] F3_B  = 3'b000;
    localparam logic [F3_WIDTH-1:0] F3_H  = 3'b001;
    localparam logic [F3_WIDTH-1:0] F3_W  = 3'b010;
    localparam logic [F3_WIDTH-1:0] F3_BU = 3'b100;
    localparam logic [F3_WIDTH-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                we;
        logic [31:0]         addr;
        logic [31:0]         wdata;
        logic [F3_WIDTH-1:0] funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for stores and extraction/extension for loads.
// DMEM_MISALIGN_ERR_EN: flag misaligned half/word accesses as errors instead of masking.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic                we,
    input  logic [F3_WIDTH-1:0] funct3,
    input  logic [1:0]          addr_lo,
    input  logic [31:0]         wdata,
    input  logic [31:0]         rword,
    output logic [BE_W-1:0]     be_c,
    output logic [31:0]         wdata_c,
    output logic [31:0]         rdata_c,
    output logic                err_c
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        misalign;

    always_comb begin
        case (addr_lo)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Any error suppresses both the write enables and the load data.
    always_comb begin
        be_c    = '0;
        wdata_c = wdata;
        rdata_c = '0;
        err_c   = 1'b0;
        if (we) begin
            case (funct3)
                F3_B: begin
                    be_c    = BE_W'(1) << addr_lo;
                    wdata_c = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{wdata[15:0]}};
                end
                F3_W:    be_c  = '1;
                default: err_c = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B:    rdata_c = {{24{rbyte[7]}}, rbyte};
                F3_H:    rdata_c = {{16{rhalf[15]}}, rhalf};
                F3_W:    rdata_c = rword;
                F3_BU:   rdata_c = {24'd0, rbyte};
                F3_HU:   rdata_c = {16'd0, rhalf};
                default: err_c   = 1'b1;
            endcase
        end
        if (misalign) begin
            err_c = 1'b1;
        end
        if (err_c) begin
            be_c    = '0;
            rdata_c = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data memory behind valid/ready request and response channels with configurable wait states.
// DMEM_MISALIGN_ERR_EN (see dmem_lane_align) turns misaligned half/word accesses into errors.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    dmem_req_t        cap, live, cur;
    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      rword;
    logic [BE_W-1:0]  be_c;
    logic [31:0]      wdata_c, rdata_c, rsp_rdata_nxt;
    logic             err_c, accept_c, commit_c;
    logic             req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic             unused_addr_hi;

    // With zero wait states the store commits on the accepting edge, so steer from the live request in IDLE.
    always_comb begin
        live = '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
        cur  = (state == ST_IDLE) ? live : cap;
    end

    assign cur_idx        = cur.addr[IDX_W+1:2];
    assign rword          = mem[cur_idx];
    assign unused_addr_hi = ^{cur.addr[31:IDX_W+2]};

    dmem_lane_align u_align (
        .we      (cur.we),
        .funct3  (cur.funct3),
        .addr_lo (cur.addr[1:0]),
        .wdata   (cur.wdata),
        .rword   (rword),
        .be_c    (be_c),
        .wdata_c (wdata_c),
        .rdata_c (rdata_c),
        .err_c   (err_c)
    );

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        accept_c      = req_valid && req_ready && (state == ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    cnt_nxt   = CNT_W'(CNT_INIT);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        commit_c      = !rst && (state != ST_RESP) && (state_nxt == ST_RESP) && cur.we && !err_c;
        req_ready_nxt = (state_nxt == ST_IDLE);
        // Response registers load in the first RESP cycle and hold until the handshake.
        rsp_valid_nxt = (state == ST_RESP) && !(rsp_valid && rsp_ready);
        if (!rsp_valid_nxt) begin
            rsp_rdata_nxt = '0;
            rsp_err_nxt   = 1'b0;
        end else if (!rsp_valid) begin
            rsp_rdata_nxt = cur.we ? '0 : rdata_c;
            rsp_err_nxt   = err_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (accept_c) begin
                cap <= live;
            end
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // Storage is not reset; byte-enabled write on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be_c[b]) begin
                    mem[cur_idx][8*b +: 8] <= wdata_c[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) share one request stream, checked against a byte-array model.
module tb_dmem_responder;

    localparam int unsigned W_A = 2;
    localparam int unsigned W_B = 0;

    logic        clk, rst;
    logic        req_valid, req_valid0, en0, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        u2_req_ready, u2_rsp_valid, u2_rsp_err;
    logic        u0_req_ready, u0_rsp_valid, u0_rsp_err;
    logic [31:0] u2_rsp_rdata, u0_rsp_rdata;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  bm [4096];
    logic [32:0] exp_q [$];
    logic [32:0] cmp_e;

    assign req_valid0 = req_valid && en0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W_A)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(u2_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(u2_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(u2_rsp_rdata), .rsp_err(u2_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W_B)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(u0_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(u0_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(u0_rsp_rdata), .rsp_err(u0_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Little-endian byte memory; accesses aligned down to their size, wrapping at 4 KiB.
    function automatic void model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                      input logic [2:0] f3, output logic [31:0] rd, output logic err);
        int unsigned size, base;
        logic [31:0] v;
        bit legal, mis;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
        mis   = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        mis = (addr % size) != 0;
`endif
        err = !legal || mis;
        rd  = '0;
        if (err) return;
        base = ((addr % 4096) / size) * size;
        if (we) begin
            for (int i = 0; i < int'(size); i++) bm[base+i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < int'(size); i++) v[8*i +: 8] = bm[base+i];
            if (!f3[2] && size < 4 && v[8*size-1]) begin
                for (int i = int'(size); i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            rd = v;
        end
    endfunction

    // Whenever either responder presents a response, it must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && (u2_rsp_valid || u0_rsp_valid)) begin
            if (exp_q.size() == 0) begin
                check("response with nothing pending", 32'(u2_rsp_valid || u0_rsp_valid), 32'd0);
            end else begin
                cmp_e = exp_q[0];
                if (u2_rsp_valid) begin
                    check("u2 rsp_rdata", u2_rsp_rdata, cmp_e[31:0]);
                    check("u2 rsp_err", 32'(u2_rsp_err), 32'(cmp_e[32]));
                    check("u2 req_ready during rsp", 32'(u2_req_ready), 32'd0);
                end
                if (u0_rsp_valid) begin
                    check("u0 rsp_rdata", u0_rsp_rdata, cmp_e[31:0]);
                    check("u0 rsp_err", 32'(u0_rsp_err), 32'(cmp_e[32]));
                    check("u0 req_ready during rsp", 32'(u0_req_ready), 32'd0);
                end
            end
        end
    end

    task automatic do_txn(input string nm, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input int hold, input bit lit_chk,
                          input logic [31:0] lit_rd, input logic lit_err);
        logic [31:0] mrd, snap;
        logic        merr;
        int          v2, v0, low2, low0, held, rel_n;
        bit          done2, done0;
        v2 = 0; v0 = 0; low2 = 0; low0 = 0; held = 0; rel_n = 0;
        done2 = 1'b0; done0 = 1'b0; snap = '0;
        model_txn(we, addr, wd, f3, mrd, merr);
        if (lit_chk) begin
            check({nm, " model rdata"}, mrd, lit_rd);
            check({nm, " model err"}, 32'(merr), 32'(lit_err));
        end
        exp_q.push_back({merr, mrd});
        @(negedge clk);
        check({nm, " u2 idle req_ready"}, 32'(u2_req_ready), 32'd1);
        check({nm, " u0 idle req_ready"}, 32'(u0_req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        rsp_ready = (hold == 0);
        @(posedge clk);
        for (int n = 1; n <= 40 && !(done2 && done0); n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (!done2) begin
                if (u2_req_ready) done2 = 1'b1; else low2++;
                if (u2_rsp_valid && v2 == 0) begin v2 = n; snap = u2_rsp_rdata; end
            end
            if (!done0) begin
                if (u0_req_ready) done0 = 1'b1; else low0++;
                if (u0_rsp_valid && v0 == 0) v0 = n;
            end
            if (rel_n != 0 && n == rel_n + 1) begin
                check({nm, " u2 done on first ready"}, 32'(done2), 32'd1);
                check({nm, " u0 done on first ready"}, 32'(done0), 32'd1);
            end
            if (hold > 0 && v2 != 0 && !rsp_ready) begin
                if (held > 0) begin
                    check({nm, " held rsp_valid"}, 32'(u2_rsp_valid), 32'd1);
                    check({nm, " held rsp_rdata"}, u2_rsp_rdata, snap);
                end
                held++;
                if (held == hold) begin rsp_ready = 1'b1; rel_n = n; end
            end
        end
        check({nm, " completed"}, 32'(done2 && done0), 32'd1);
        check({nm, " u2 latency"}, 32'(v2 - 1), 32'(1 + W_A));
        check({nm, " u0 latency"}, 32'(v0 - 1), 32'(1 + W_B));
        if (hold == 0) begin
            check({nm, " u2 req_ready low cycles"}, 32'(low2), 32'(2 + W_A));
            check({nm, " u0 req_ready low cycles"}, 32'(low0), 32'(2 + W_B));
        end
        void'(exp_q.pop_front());
        rsp_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; en0 = 1'b1; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 4096; i++) bm[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset u2 req_ready", 32'(u2_req_ready), 32'd1);
        check("reset u2 rsp_valid", 32'(u2_rsp_valid), 32'd0);
        check("reset u2 rsp_rdata", u2_rsp_rdata, 32'd0);
        check("reset u2 rsp_err", 32'(u2_rsp_err), 32'd0);
        check("reset u0 req_ready", 32'(u0_req_ready), 32'd1);
        check("reset u0 rsp_valid", 32'(u0_rsp_valid), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);

        do_txn("init sw 0x20", 1'b1, 32'h20, 32'h0000_1234, 3'b010, 0, 1'b0, 32'h0, 1'b0);
        do_txn("init sw 0x40", 1'b1, 32'h40, 32'hCAFE_F00D, 3'b010, 0, 1'b0, 32'h0, 1'b0);
        do_txn("sw deadbeef",  1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, 1'b1, 32'h0, 1'b0);
        do_txn("lw 0x10",      1'b0, 32'h10, 32'h0,         3'b010, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        do_txn("sb 0x11",      1'b1, 32'h11, 32'h0000_007F, 3'b000, 0, 1'b1, 32'h0, 1'b0);
        do_txn("lb 0x13",      1'b0, 32'h13, 32'h0,         3'b000, 0, 1'b1, 32'hFFFF_FFDE, 1'b0);
        do_txn("lbu 0x13",     1'b0, 32'h13, 32'h0,         3'b100, 0, 1'b1, 32'h0000_00DE, 1'b0);
        do_txn("lw after sb",  1'b0, 32'h10, 32'h0,         3'b010, 0, 1'b1, 32'hDEAD_7FEF, 1'b0);
        do_txn("sh 0x22",      1'b1, 32'h22, 32'h0000_8001, 3'b001, 0, 1'b1, 32'h0, 1'b0);
        do_txn("lh 0x22",      1'b0, 32'h22, 32'h0,         3'b001, 0, 1'b1, 32'hFFFF_8001, 1'b0);
        do_txn("lhu 0x22",     1'b0, 32'h22, 32'h0,         3'b101, 0, 1'b1, 32'h0000_8001, 1'b0);
        do_txn("lw after sh",  1'b0, 32'h20, 32'h0,         3'b010, 0, 1'b1, 32'h8001_1234, 1'b0);
        do_txn("lw backpress", 1'b0, 32'h10, 32'h0,         3'b010, 5, 1'b1, 32'hDEAD_7FEF, 1'b0);
        do_txn("store f3 100", 1'b1, 32'h10, 32'hFFFF_FFFF, 3'b100, 0, 1'b1, 32'h0, 1'b1);
        do_txn("lw after bad", 1'b0, 32'h10, 32'h0,         3'b010, 0, 1'b1, 32'hDEAD_7FEF, 1'b0);
        do_txn("load f3 011",  1'b0, 32'h10, 32'h0,         3'b011, 0, 1'b1, 32'h0, 1'b1);
        do_txn("load f3 111",  1'b0, 32'h10, 32'h0,         3'b111, 0, 1'b1, 32'h0, 1'b1);
        do_txn("lw wrap",      1'b0, 32'h0000_1010, 32'h0,  3'b010, 0, 1'b1, 32'hDEAD_7FEF, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
        do_txn("lw 0x12",      1'b0, 32'h12, 32'h0,         3'b010, 0, 1'b1, 32'h0, 1'b1);
        do_txn("lh 0x11",      1'b0, 32'h11, 32'h0,         3'b001, 0, 1'b1, 32'h0, 1'b1);
`else
        do_txn("lw 0x12",      1'b0, 32'h12, 32'h0,         3'b010, 0, 1'b1, 32'hDEAD_7FEF, 1'b0);
        do_txn("lh 0x11",      1'b0, 32'h11, 32'h0,         3'b001, 0, 1'b1, 32'h0000_7FEF, 1'b0);
`endif

        // Reset lands while the 2-wait responder holds an uncommitted store.
        en0 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h1234_5678; req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst test in wait req_ready", 32'(u2_req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst mid-op req_ready", 32'(u2_req_ready), 32'd1);
        check("rst mid-op rsp_valid", 32'(u2_rsp_valid), 32'd0);
        check("rst mid-op rsp_rdata", u2_rsp_rdata, 32'd0);
        check("rst mid-op rsp_err", 32'(u2_rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en0 = 1'b1;
        @(negedge clk);
        do_txn("lw 0x40 after rst", 1'b0, 32'h40, 32'h0, 3'b010, 0, 1'b1, 32'hCAFE_F00D, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
